// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Hazard and forwarding controller for the 5-stage xgriscv pipeline.
//   Tracks shadow copies of the ID/EX, EX/MEM and MEM/WB control fields,
//   drives the EX-stage operand-forwarding selects, and sequences stalls and
//   flushes for load-use hazards, slow data memory and taken branches.
//
//   Optional feature: define HAZARD_PERF_CNT_EN to add the stall_cycles
//   counter output (counts every cycle with stall_if=1, wraps, reset-cleared).
//
// Ports
//   clk, reset        core clock, synchronous active-high reset
//   id_*              decoded fields of the instruction currently in ID
//   ex_branch_taken   EX resolved a taken branch/jump this cycle
//   dmem_ready        data memory finishes the MEM-stage access this cycle
//   fwd_a, fwd_b      EX operand selects: 00 ID/EX, 01 WB result, 10 EX/MEM ALU
//   stall_if..mem     hold PC / IF/ID / ID/EX / EX/MEM
//   flush_id/ex/wb    bubble into IF/ID / ID/EX / MEM/WB
//   state_o           controller mode of the current cycle (debug)
//   stall_cycles      stall counter (HAZARD_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              ex_branch_taken,
  input  logic              dmem_ready,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              flush_wb,
  output logic [1:0]        state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] stall_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10,
    MEM_WAIT   = 2'b11
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } ex_stage_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
  } mem_stage_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } wb_stage_t;

  ex_stage_t  ex_q;
  mem_stage_t mem_q;
  wb_stage_t  wb_q;
  state_t     state_q;
  state_t     mode;

  logic mem_wait_c;
  logic load_use_c;

  assign mem_wait_c = mem_q.valid && (mem_q.memread || mem_q.memwrite) && !dmem_ready;

  assign load_use_c = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && id_valid &&
                      ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_q.rd)));

  // Mode decision and stall/flush outputs for the current cycle.
  // NOTE: every output gets a default before any branch, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    mode      = RUN;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_wb  = 1'b0;
    if (reset) begin
      // Reset overrides everything so a pending wait or stall aborts at once.
      mode = RUN;
    end else if (mem_wait_c) begin
      // EX is frozen, so a taken branch there simply re-asserts after the wait.
      mode      = MEM_WAIT;
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if (ex_branch_taken) begin
      // The younger instruction in ID is on the wrong path, so any load-use
      // stall against it is dropped.
      mode     = FLUSH;
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use_c && (state_q != LOAD_STALL)) begin
      // One bubble is always enough: afterwards the load sits in WB and the
      // dependency is served by the 01 forwarding path.
      mode     = LOAD_STALL;
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

  assign state_o = mode;

  // Forwarding selects; the younger EX/MEM producer wins over MEM/WB. A load
  // in MEM has no data yet, and x0 is never a forwarding source.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!reset) begin
      if (mem_q.regwrite && !mem_q.memread && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs1))
        fwd_a = 2'b10;
      else if (wb_q.regwrite && (wb_q.rd != '0) && (wb_q.rd == ex_q.rs1))
        fwd_a = 2'b01;

      if (mem_q.regwrite && !mem_q.memread && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs2))
        fwd_b = 2'b10;
      else if (wb_q.regwrite && (wb_q.rd != '0) && (wb_q.rd == ex_q.rs2))
        fwd_b = 2'b01;
    end
  end

  // Shadow pipeline and mode register.
  // NOTE: sequential state uses non-blocking assignments so every stage reads
  // the pre-edge value of its neighbour, exactly like the real pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= RUN;
    end else begin
      state_q <= mode;
      if (stall_mem) begin
        // EX and MEM hold; WB receives a bubble while memory is busy.
        wb_q <= '0;
      end else begin
        wb_q.rd        <= mem_q.rd;
        wb_q.regwrite  <= mem_q.regwrite;
        mem_q.valid    <= ex_q.valid;
        mem_q.rd       <= ex_q.rd;
        mem_q.regwrite <= ex_q.regwrite;
        mem_q.memread  <= ex_q.memread;
        mem_q.memwrite <= ex_q.memwrite;
        if (flush_ex) begin
          ex_q <= '0;
        end else begin
          ex_q.valid    <= id_valid;
          ex_q.rs1      <= id_rs1;
          ex_q.rs2      <= id_rs2;
          ex_q.rd       <= id_rd;
          ex_q.regwrite <= id_valid && id_regwrite;
          ex_q.memread  <= id_valid && id_memread;
          ex_q.memwrite <= id_valid && id_memwrite;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall_if)
      stall_cycles <= stall_cycles + PERF_W'(1);
  end
`else
  localparam int unused_perf_w = PERF_W;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//   Directed self-checking bench for hazard_fwd_ctrl. Inputs change 1 ns after
//   the rising edge and outputs are checked 1 ns later, away from the edge.
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

  localparam logic [1:0] S_RUN        = 2'b00;
  localparam logic [1:0] S_LOAD_STALL = 2'b01;
  localparam logic [1:0] S_FLUSH      = 2'b10;
  localparam logic [1:0] S_MEM_WAIT   = 2'b11;

  // Control vector order: stall_if, stall_id, stall_ex, stall_mem,
  // flush_id, flush_ex, flush_wb.
  localparam logic [6:0] C_NONE  = 7'b000_0000;
  localparam logic [6:0] C_LOAD  = 7'b110_0010;
  localparam logic [6:0] C_WAIT  = 7'b111_1001;
  localparam logic [6:0] C_FLUSH = 7'b000_0110;

  logic       clk;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2;
  logic       id_regwrite, id_memread, id_memwrite;
  logic       ex_branch_taken;
  logic       dmem_ready;
  logic [1:0] fwd_a, fwd_b;
  logic       stall_if, stall_id, stall_ex, stall_mem;
  logic       flush_id, flush_ex, flush_wb;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  hazard_fwd_ctrl #(.REG_AW(5), .PERF_W(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .id_regwrite     (id_regwrite),
    .id_memread      (id_memread),
    .id_memwrite     (id_memwrite),
    .ex_branch_taken (ex_branch_taken),
    .dmem_ready      (dmem_ready),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .stall_ex        (stall_ex),
    .stall_mem       (stall_mem),
    .flush_id        (flush_id),
    .flush_ex        (flush_ex),
    .flush_wb        (flush_wb),
    .state_o         (state_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctl();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw);
    id_valid    = v;
    id_rs1      = r1;
    id_rs2      = r2;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_memwrite = mw;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  initial begin
    reset           = 1'b1;
    ex_branch_taken = 1'b0;
    dmem_ready      = 1'b1;
    nop();

    // ---------------- reset state ----------------
    repeat (2) tick();
    check("reset_ctl", 32'(ctl()), 32'(C_NONE));
    check("reset_state", 32'(state_o), 32'(S_RUN));
    reset = 1'b0;
    settle();
    check("post_reset_ctl", 32'(ctl()), 32'(C_NONE));
    check("post_reset_fwd", 32'({fwd_a, fwd_b}), 32'(4'b0000));
`ifdef HAZARD_PERF_CNT_EN
    check("post_reset_cnt", stall_cycles, 32'd0);
`endif

    // ---------------- add x5,x1,x2 ; sub x6,x5,x3 ----------------
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    settle();
    check("alu_alu_no_stall_id", 32'(ctl()), 32'(C_NONE));
    tick();
    nop();
    settle();
    check("alu_alu_fwd_a", 32'(fwd_a), 32'(2'b10));
    check("alu_alu_fwd_b", 32'(fwd_b), 32'(2'b00));
    check("alu_alu_no_stall_ex", 32'(ctl()), 32'(C_NONE));
    drain();

    // ---------------- add x5 ; nop ; or x7,x0,x5 ----------------
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    set_id(1'b1, 5'd0, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    settle();
    check("wb_fwd_b", 32'(fwd_b), 32'(2'b01));
    check("wb_fwd_a_x0", 32'(fwd_a), 32'(2'b00));

    // ---------------- add x0,x1,x2 ; add x1,x0,x0 ; add x3,x0,x0 ----------------
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    settle();
    check("x0_mem_no_fwd", 32'({fwd_a, fwd_b}), 32'(4'b0000));
    tick();
    nop();
    settle();
    check("x0_wb_no_fwd", 32'({fwd_a, fwd_b}), 32'(4'b0000));
    drain();

    // ---------------- add x5 ; sw x5,0(x2) : store data via fwd_b ----------------
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd2, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    nop();
    settle();
    check("store_fwd", 32'({fwd_a, fwd_b}), 32'(4'b0010));
    check("store_no_stall", 32'(ctl()), 32'(C_NONE));
    drain();

    // ---------------- lw x4,0(x1) ; add x8,x4,x4 ----------------
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    settle();
    check("lu_ctl", 32'(ctl()), 32'(C_LOAD));
    check("lu_state", 32'(state_o), 32'(S_LOAD_STALL));
    tick();
    settle();
    check("lu_release_ctl", 32'(ctl()), 32'(C_NONE));
    check("lu_release_state", 32'(state_o), 32'(S_RUN));
    tick();
    nop();
    settle();
    check("lu_fwd", 32'({fwd_a, fwd_b}), 32'(4'b0101));
    drain();

    // ---------------- back-to-back loads: lw x4 ; lw x5,0(x4) ; add x9,x5,x0 ----------------
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    settle();
    check("ll_stall1", 32'(state_o), 32'(S_LOAD_STALL));
    tick();
    tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    settle();
    check("ll_stall2", 32'(ctl()), 32'(C_LOAD));
    check("ll_lw2_fwd_a", 32'(fwd_a), 32'(2'b01));
    drain();

    // ---------------- 3-cycle memory wait (counter starts from reset) ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    dmem_ready = 1'b0;
    ex_branch_taken = 1'b1;
    settle();
    check("mw_branch_ignored", 32'(ctl()), 32'(C_WAIT));
    ex_branch_taken = 1'b0;
    for (int k = 1; k < 3; k++) begin
      tick();
      settle();
      check("mw_ctl", 32'(ctl()), 32'(C_WAIT));
      check("mw_state", 32'(state_o), 32'(S_MEM_WAIT));
    end
    tick();
    dmem_ready = 1'b1;
    settle();
    check("mw_release_ctl", 32'(ctl()), 32'(C_NONE));
    check("mw_release_state", 32'(state_o), 32'(S_RUN));
`ifdef HAZARD_PERF_CNT_EN
    check("mw_stall_cycles", stall_cycles, 32'd3);
    tick();
    settle();
    check("mw_stall_cycles_hold", stall_cycles, 32'd3);
`endif
    drain();

    // ---------------- taken branch with a load-use pending ----------------
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;
    settle();
    check("br_ctl", 32'(ctl()), 32'(C_FLUSH));
    check("br_state", 32'(state_o), 32'(S_FLUSH));
    tick();
    ex_branch_taken = 1'b0;
    nop();
    settle();
    check("br_after_ctl", 32'(ctl()), 32'(C_NONE));
    check("br_after_state", 32'(state_o), 32'(S_RUN));
    drain();

    // ---------------- reset in cycle 2 of a 4-cycle memory wait ----------------
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    nop();
    tick();
    dmem_ready = 1'b0;
    settle();
    check("rw_wait_c1", 32'(ctl()), 32'(C_WAIT));
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("rw_ctl", 32'(ctl()), 32'(C_NONE));
    check("rw_fwd", 32'({fwd_a, fwd_b}), 32'(4'b0000));
    check("rw_state", 32'(state_o), 32'(S_RUN));
`ifdef HAZARD_PERF_CNT_EN
    check("rw_cnt", stall_cycles, 32'd0);
`endif
    dmem_ready = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
